ram_access_arbiter: RTL and testbench

Sequencing and arbitration front-end for the single-port zero-delay data RAM. Shares the RAM between the instruction-fetch requester (word reads only) and the load/store requester (byte/half/word, signed/unsigned loads, sub-word stores). Performs byte-lane extraction and sign extension for loads, and read-modify-write for sub-word stores. Sits between the RV32I core's fetch/LSU stages and the RAM.

---
 rtl/ram_access_arbiter_pkg.sv | 19 +
 rtl/ram_access_arbiter_if.sv | 48 ++++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/ram_access_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_access_arbiter_pkg.sv
// Shared types for the data-RAM arbiter: FSM states, access sizes, lane count.
package ram_arb_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RMW_WR = 2'd2
    } state_t;

    // 2'b11 is the illegal size and is deliberately left out of the enum
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_t;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Fetch, load/store and RAM-side signals of the data-RAM arbiter.
// slave = arbiter view, master = requesters plus RAM (testbench) view.
interface ram_access_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic              ls_unsigned;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_err;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane logic for one RAM word: load extract/extend, sub-word store merge,
// misalignment and illegal-size detection. Purely combinational.
module mem_lane_align
    import ram_arb_pkg::*;
(
    input  logic              is_fetch,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [1:0]        addr_lo,
    input  logic [LANES*8-1:0] rdata,
    input  logic [LANES*8-1:0] wdata,
    output logic              err,
    output logic [LANES*8-1:0] load_data,
    output logic [LANES*8-1:0] merged
);

    logic [7:0]  rl [LANES];
    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            rl[k] = rdata[8*k +: 8];
        end
        bsel = rl[addr_lo];
        hsel = {rl[{addr_lo[1], 1'b1}], rl[{addr_lo[1], 1'b0}]};

        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = {{24{~uns & bsel[7]}}, bsel};
            SZ_HALF: load_data = {{16{~uns & hsel[15]}}, hsel};
            default: load_data = rdata;
        endcase

        merged = rdata;
        for (int k = 0; k < LANES; k++) begin
            case (size)
                SZ_BYTE: if (2'(k) == addr_lo) merged[8*k +: 8] = wdata[7:0];
                SZ_HALF: if ((k / 2) == int'(addr_lo[1]))
                             merged[8*k +: 8] = (k % 2 == 1) ? wdata[15:8] : wdata[7:0];
                default: merged[8*k +: 8] = wdata[8*k +: 8];
            endcase
        end

        // fetches are always words; byte accesses can never be misaligned
        if (is_fetch) begin
            err = (addr_lo != 2'b00);
        end else begin
            err = (size == 2'b11)
                | ((size == SZ_HALF) & addr_lo[0])
                | ((size == SZ_WORD) & (addr_lo != 2'b00));
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single-port data RAM between instruction fetch and load/store:
// round-robin grant in IDLE, one access per 2 cycles, sub-word stores via read-modify-write.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    ram_access_arbiter_if.slave   bus
);

    state_t            state_q, state_d;
    logic              favor_ls_q, favor_ls_d;
    logic              is_fetch_q, is_fetch_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] merged_q, merged_d;

    logic              if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_err_q, if_err_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              ls_err_q, ls_err_d;

    logic              if_gnt, ls_gnt;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;

    logic              lane_err;
    logic [DATA_W-1:0] lane_load;
    logic [DATA_W-1:0] lane_merged;

    mem_lane_align u_align (
        .is_fetch  (is_fetch_q),
        .size      (size_q),
        .uns       (uns_q),
        .addr_lo   (addr_q[1:0]),
        .rdata     (bus.ram_rdata),
        .wdata     (wdata_q),
        .err       (lane_err),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    always_comb begin
        state_d     = state_q;
        favor_ls_d  = favor_ls_q;
        is_fetch_d  = is_fetch_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        merged_d    = merged_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        ls_rvalid_d = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        ls_err_d    = ls_err_q;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        ram_we      = 1'b0;

        case (state_q)
            IDLE: begin
                // grants are combinational, so keep them quiet while reset is held
                ls_gnt = ~reset & bus.ls_req & (~bus.if_req | favor_ls_q);
                if_gnt = ~reset & bus.if_req & (~bus.ls_req | ~favor_ls_q);
                if (ls_gnt) begin
                    is_fetch_d = 1'b0;
                    we_d       = bus.ls_we;
                    size_d     = bus.ls_size;
                    uns_d      = bus.ls_unsigned;
                    addr_d     = bus.ls_addr;
                    wdata_d    = bus.ls_wdata;
                    favor_ls_d = 1'b0;
                    state_d    = ACCESS;
                end else if (if_gnt) begin
                    is_fetch_d = 1'b1;
                    we_d       = 1'b0;
                    size_d     = SZ_WORD;
                    uns_d      = 1'b0;
                    addr_d     = bus.if_addr;
                    wdata_d    = '0;
                    favor_ls_d = 1'b1;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                ram_addr = {addr_q[ADDR_W-1:2], 2'b00};
                state_d  = IDLE;
                if (is_fetch_q) begin
                    if_rvalid_d = 1'b1;
                    if_err_d    = lane_err;
                    if_rdata_d  = lane_err ? '0 : lane_load;
                end else if (lane_err) begin
                    ls_rvalid_d = 1'b1;
                    ls_err_d    = 1'b1;
                    ls_rdata_d  = '0;
                end else if (!we_q) begin
                    ls_rvalid_d = 1'b1;
                    ls_err_d    = 1'b0;
                    ls_rdata_d  = lane_load;
                end else if (size_q == SZ_WORD) begin
                    ram_we      = 1'b1;
                    ram_wdata   = wdata_q;
                    ls_rvalid_d = 1'b1;
                    ls_err_d    = 1'b0;
                    ls_rdata_d  = '0;
                end else begin
                    merged_d = lane_merged;
                    state_d  = RMW_WR;
                end
            end
            RMW_WR: begin
                ram_addr    = {addr_q[ADDR_W-1:2], 2'b00};
                ram_we      = 1'b1;
                ram_wdata   = merged_q;
                ls_rvalid_d = 1'b1;
                ls_err_d    = 1'b0;
                ls_rdata_d  = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            favor_ls_q  <= 1'b1;
            is_fetch_q  <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            merged_q    <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
            ls_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            favor_ls_q  <= favor_ls_d;
            is_fetch_q  <= is_fetch_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            merged_q    <= merged_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
            ls_err_q    <= ls_err_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.ls_gnt    = ls_gnt;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.ls_err    = ls_err_q;
    assign bus.ram_addr  = ram_addr;
    assign bus.ram_wdata = ram_wdata;
    assign bus.ram_we    = ram_we;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Testbench for ram_access_arbiter: bench-side RAM, transaction-level reference model,
// directed cases with literal expectations, then randomized two-requester traffic.
module tb_ram_access_arbiter;

    logic clock;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    ram_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ram_access_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // bench RAM (device memory) and the model's shadow copy, 64 words aliased on addr[7:2]
    logic [31:0] mem [64];
    logic [31:0] shm [64];
    assign bus.ram_rdata = mem[bus.ram_addr[7:2]];
    always @(posedge clock) if (bus.ram_we) mem[bus.ram_addr[7:2]] <= bus.ram_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic logic m_err(input logic fetch, input logic [31:0] a, input logic [1:0] sz);
        if (fetch) return (a % 4) != 0;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] wd);
        int          sh;
        logic [31:0] mask;
        sh   = (sz == 2'd0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    // expectation slots indexed by cycle mod 8
    logic        s_act [8] = '{default: 1'b0};
    logic        s_we  [8] = '{default: 1'b0};
    logic [31:0] s_adr [8] = '{default: 32'h0};
    logic [31:0] s_wd  [8] = '{default: 32'h0};
    logic        s_irv [8] = '{default: 1'b0};
    logic        s_ier [8] = '{default: 1'b0};
    logic [31:0] s_ird [8] = '{default: 32'h0};
    logic        s_lrv [8] = '{default: 1'b0};
    logic        s_ler [8] = '{default: 1'b0};
    logic [31:0] s_lrd [8] = '{default: 32'h0};
    int          free_cyc = 0;
    logic        favor_ls = 1'b1;

    task automatic clr_slot(input int s);
        s_act[s] = 0; s_we[s] = 0; s_adr[s] = 0; s_wd[s] = 0;
        s_irv[s] = 0; s_ier[s] = 0; s_ird[s] = 0;
        s_lrv[s] = 0; s_ler[s] = 0; s_lrd[s] = 0;
    endtask

    always @(negedge clock) begin
        int s, s1, s2, s3, ix;
        logic egi, egl, e;
        logic [31:0] a, nw;
        if (reset) begin
            chk("outs_in_reset", 32'(|{bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.if_err,
                 bus.ls_gnt, bus.ls_rvalid, bus.ls_rdata, bus.ls_err,
                 bus.ram_addr, bus.ram_wdata, bus.ram_we}), 32'h0);
            for (int i = 0; i < 8; i++) clr_slot(i);
            free_cyc = cyc;
            favor_ls = 1'b1;
        end else begin
            s  = cyc % 8;
            s1 = (cyc + 1) % 8;
            s2 = (cyc + 2) % 8;
            s3 = (cyc + 3) % 8;
            egi = (cyc >= free_cyc) && bus.if_req && (!bus.ls_req || !favor_ls);
            egl = (cyc >= free_cyc) && bus.ls_req && (!bus.if_req || favor_ls);
            chk("if_gnt", bus.if_gnt, egi);
            chk("ls_gnt", bus.ls_gnt, egl);
            chk("ram_we", bus.ram_we, s_we[s]);
            chk("ram_addr", bus.ram_addr, s_act[s] ? s_adr[s] : 32'h0);
            if (s_we[s] || !s_act[s]) chk("ram_wdata", bus.ram_wdata, s_wd[s]);
            chk("if_rvalid", bus.if_rvalid, s_irv[s]);
            chk("ls_rvalid", bus.ls_rvalid, s_lrv[s]);
            if (s_irv[s]) begin
                chk("if_rdata", bus.if_rdata, s_ird[s]);
                chk("if_err", bus.if_err, s_ier[s]);
            end
            if (s_lrv[s]) begin
                chk("ls_rdata", bus.ls_rdata, s_lrd[s]);
                chk("ls_err", bus.ls_err, s_ler[s]);
            end
            clr_slot(s);
            if (egl || egi) begin
                a  = egl ? bus.ls_addr : bus.if_addr;
                ix = int'(a[7:2]);
                s_act[s1] = 1'b1;
                s_adr[s1] = a & 32'hFFFF_FFFC;
                free_cyc  = cyc + 2;
                favor_ls  = egi;
                if (egi) begin
                    e = m_err(1'b1, a, 2'd2);
                    s_irv[s2] = 1'b1;
                    s_ier[s2] = e;
                    s_ird[s2] = e ? 32'h0 : shm[ix];
                end else begin
                    e = m_err(1'b0, a, bus.ls_size);
                    s_lrv[s2] = 1'b1;
                    s_ler[s2] = e;
                    if (!e && !bus.ls_we) begin
                        s_lrd[s2] = m_load(shm[ix], a, bus.ls_size, bus.ls_unsigned);
                    end else if (!e && bus.ls_size == 2'd2) begin
                        s_we[s1] = 1'b1;
                        s_wd[s1] = bus.ls_wdata;
                        shm[ix]  = bus.ls_wdata;
                    end else if (!e) begin
                        nw = m_merge(shm[ix], a, bus.ls_size, bus.ls_wdata);
                        s_lrv[s2] = 1'b0;
                        s_act[s2] = 1'b1;
                        s_adr[s2] = s_adr[s1];
                        s_we[s2]  = 1'b1;
                        s_wd[s2]  = nw;
                        s_lrv[s3] = 1'b1;
                        shm[ix]   = nw;
                        free_cyc  = cyc + 3;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        mem[a[7:2]] = v;
        shm[a[7:2]] = v;
    endtask

    // called just after a rising edge with the DUT idle
    task automatic ls_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        logic got;
        rd = 32'h0; er = 1'b0;
        bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_size = sz;
        bus.ls_unsigned = uns; bus.ls_addr = a; bus.ls_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (bus.ls_gnt) got = 1'b1;
            else begin @(posedge clock); #1; end
        end
        chk("ls_gnt_wait", got, 1'b1);
        @(posedge clock); #1;
        bus.ls_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (bus.ls_rvalid) begin got = 1'b1; rd = bus.ls_rdata; er = bus.ls_err; end
        end
        chk("ls_rvalid_wait", got, 1'b1);
        @(posedge clock); #1;
    endtask

    task automatic if_op(input logic [31:0] a, output logic [31:0] rd, output logic er);
        logic got;
        rd = 32'h0; er = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = a;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (bus.if_gnt) got = 1'b1;
            else begin @(posedge clock); #1; end
        end
        chk("if_gnt_wait", got, 1'b1);
        @(posedge clock); #1;
        bus.if_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (bus.if_rvalid) begin got = 1'b1; rd = bus.if_rdata; er = bus.if_err; end
        end
        chk("if_rvalid_wait", got, 1'b1);
        @(posedge clock); #1;
    endtask

    task automatic rand_ls();
        logic [1:0]  sz;
        logic [31:0] a;
        sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
        a  = $urandom;
        if ($urandom % 4 != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
        end
        bus.ls_req = ($urandom % 3 != 0);
        bus.ls_we = 1'($urandom); bus.ls_size = sz; bus.ls_unsigned = 1'($urandom);
        bus.ls_addr = a; bus.ls_wdata = $urandom;
    endtask

    task automatic rand_if();
        logic [31:0] a;
        a = $urandom;
        if ($urandom % 6 != 0) a[1:0] = 2'b00;
        bus.if_req = ($urandom % 3 != 0);
        bus.if_addr = a;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er, gi, gl, got;
        int          gcyc [$];
        logic        gwho [$];

        reset = 1'b1;
        bus.if_req = 0; bus.if_addr = 0;
        bus.ls_req = 0; bus.ls_we = 0; bus.ls_size = 0; bus.ls_unsigned = 0;
        bus.ls_addr = 0; bus.ls_wdata = 0;
        for (int i = 0; i < 64; i++) begin mem[i] = $urandom; shm[i] = mem[i]; end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        set_word(32'h100, 32'h8899AABB);
        ls_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er);
        chk("word_load_data", rd, 32'h8899AABB);
        chk("word_load_err", er, 1'b0);

        set_word(32'h100, 32'h80FF7F01);
        ls_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, rd, er);
        chk("lb_signed", rd, 32'hFFFFFF80);
        ls_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, rd, er);
        chk("lbu", rd, 32'h00000080);
        ls_op(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, rd, er);
        chk("lh_signed", rd, 32'hFFFF80FF);

        set_word(32'h100, 32'h11223344);
        ls_op(1'b1, 2'd0, 1'b0, 32'h101, 32'h000000A5, rd, er);
        chk("sb_rdata", rd, 32'h0);
        chk("sb_ram", mem[0], 32'h1122A544);
        set_word(32'h100, 32'h11223344);
        ls_op(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000BEEF, rd, er);
        chk("sh_ram", mem[0], 32'hBEEF3344);

        ls_op(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, rd, er);
        chk("err_word_mis", {rd[30:0], er}, 32'h1);
        ls_op(1'b1, 2'd1, 1'b0, 32'h101, 32'h1234, rd, er);
        chk("err_half_store", {rd[30:0], er}, 32'h1);
        chk("err_half_noram", mem[0], 32'hBEEF3344);
        ls_op(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, rd, er);
        chk("err_size3", {rd[30:0], er}, 32'h1);
        if_op(32'h006, rd, er);
        chk("err_fetch", {rd[30:0], er}, 32'h1);

        // both requesters held: last grant was the fetch, so LSU goes first
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_size = 2'd2; bus.ls_addr = 32'h100;
        bus.if_req = 1; bus.if_addr = 32'h104;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (bus.ls_gnt || bus.if_gnt) begin gcyc.push_back(cyc); gwho.push_back(bus.ls_gnt); end
            @(posedge clock); #1;
        end
        bus.ls_req = 0; bus.if_req = 0;
        chk("rr_count", gcyc.size(), 8);
        for (int k = 0; k < gcyc.size(); k++) begin
            chk("rr_order", gwho[k], (k % 2 == 0));
            if (k > 0) chk("rr_spacing", gcyc[k] - gcyc[k-1], 2);
        end
        repeat (4) @(posedge clock);
        #1;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            gi = bus.if_gnt; gl = bus.ls_gnt;
            @(posedge clock); #1;
            if (gl || !bus.ls_req || $urandom % 20 == 0) rand_ls();
            if (gi || !bus.if_req || $urandom % 20 == 0) rand_if();
        end
        bus.ls_req = 0; bus.if_req = 0;
        repeat (6) @(posedge clock);
        #1;

        // reset in the RMW write cycle must abort the write
        set_word(32'h140, 32'h11223344);
        bus.ls_req = 1; bus.ls_we = 1; bus.ls_size = 2'd0; bus.ls_unsigned = 0;
        bus.ls_addr = 32'h141; bus.ls_wdata = 32'h5A;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (bus.ls_gnt) got = 1'b1;
            else begin @(posedge clock); #1; end
        end
        chk("rst_gnt_wait", got, 1'b1);
        @(posedge clock); #1;
        bus.ls_req = 0;
        @(posedge clock); #1;
        chk("rmw_we_before_rst", bus.ram_we, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("rmw_we_after_rst", bus.ram_we, 1'b0);
        chk("rmw_addr_after_rst", bus.ram_addr, 32'h0);
        @(negedge clock);
        @(posedge clock); #1;
        set_word(32'h140, 32'h11223344);
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_size = 2'd2; bus.ls_addr = 32'h140;
        reset = 1'b0;
        #1;
        chk("gnt_after_rst", bus.ls_gnt, 1'b1);
        @(posedge clock); #1;
        bus.ls_req = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (bus.ls_rvalid) begin got = 1'b1; rd = bus.ls_rdata; end
        end
        chk("rst_load_wait", got, 1'b1);
        chk("rst_write_aborted", rd, 32'h11223344);
        repeat (3) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
